// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared Funct3 codes, access sizes and responder FSM states
// Contents: F3_* load/store size codes, dmem_state_e, dmem_size_e, f3_size()
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } dmem_size_e;

    // Undefined codes (011, 110, 111) fall through to a full-word access.
    function automatic dmem_size_e f3_size(input logic [2:0] f3);
        dmem_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - combinational load lane select and sign/zero extension
// Ports: word (SRAM read word), offset (byte offset), funct3 (load kind), data (extended result)
module dmem_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder between decode pipeline and a fixed-latency SRAM
// Pipeline side: MemRead, MemWrite, Funct3, Addr, WrData in; RdData, Stall, Done, MisalignErr out
// SRAM side: mem_en, mem_we, mem_be, mem_addr, mem_wdata out; mem_rdata in
// Parameters: MEM_LAT (SRAM read latency 1..4), WORD_AW (word-address width)
// Option: DMEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses with MisalignErr;
//         otherwise the offending low address bits are cleared and the access proceeds.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int WORD_AW = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [2:0]         Funct3,
    input  logic [31:0]        Addr,
    input  logic [31:0]        WrData,
    output logic [31:0]        RdData,
    output logic               Stall,
    output logic               Done,
    output logic               MisalignErr,
    output logic               mem_en,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    // Last WAIT cycle index; WAIT is skipped entirely when MEM_LAT == 1.
    localparam logic [1:0] WAIT_LAST = (MEM_LAT >= 2) ? 2'(MEM_LAT - 2) : 2'd0;

    dmem_state_e        state_q, state_d;
    logic [WORD_AW-1:0] waddr_q, waddr_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic               store_q, store_d;
    logic               err_q, err_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_q, rd_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               req;
    logic               reject;
    dmem_size_e         size;
    logic [1:0]         off_new;
    logic [3:0]         be_new;
    logic [31:0]        wdata_new;
    logic [31:0]        load_data;
    logic               resp_upd;
    logic [31:0]        rd_new;
    logic               unused_addr;

    assign unused_addr = ^Addr[31:WORD_AW+2];
    assign req         = MemRead | MemWrite;
    assign size        = f3_size(Funct3);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign reject = ((size == SZ_H) && Addr[0]) || ((size == SZ_W) && (Addr[1:0] != 2'b00));
`else
    assign reject = 1'b0;
`endif

    // Offset is forced to natural alignment; stores replicate data across lanes.
    always_comb begin
        case (size)
            SZ_B: begin
                off_new   = Addr[1:0];
                be_new    = 4'b0001 << off_new;
                wdata_new = {4{WrData[7:0]}};
            end
            SZ_H: begin
                off_new   = {Addr[1], 1'b0};
                be_new    = 4'b0011 << off_new;
                wdata_new = {2{WrData[15:0]}};
            end
            default: begin
                off_new   = 2'b00;
                be_new    = 4'b1111;
                wdata_new = WrData;
            end
        endcase
    end

    dmem_load_align u_align (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // RdData follows the SRAM word during RESP of a load (or rejected access) and
    // is captured so it holds afterwards; stores leave it untouched.
    always_comb begin
        resp_upd = (state_q == RESP) && (!store_q || err_q);
        rd_new   = err_q ? 32'h0000_0000 : load_data;
        rd_d     = resp_upd ? rd_new : rd_q;
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        store_d = store_q;
        err_d   = err_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    waddr_d = Addr[WORD_AW+1:2];
                    off_d   = off_new;
                    f3_d    = Funct3;
                    store_d = MemWrite;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    err_d   = reject;
                    state_d = reject ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (store_q || (MEM_LAT == 1)) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'd0;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            off_q   <= 2'b00;
            f3_q    <= F3_W;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0000_0000;
            rd_q    <= 32'h0000_0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            err_q   <= err_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall is gated by reset_n so it stays low while reset holds the block.
    assign Stall       = reset_n && (((state_q == IDLE) && req) || (state_q == ISSUE) || (state_q == WAIT));
    assign Done        = (state_q == RESP);
    assign MisalignErr = (state_q == RESP) && err_q;
    assign mem_en      = (state_q == ISSUE);
    assign mem_we      = (state_q == ISSUE) && store_q;
    assign mem_be      = ((state_q == ISSUE) && store_q) ? be_q : 4'b0000;
    assign mem_addr    = waddr_q;
    assign mem_wdata   = wdata_q;
    assign RdData      = resp_upd ? rd_new : rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (MEM_LAT=2)
module tb_dmem_responder;
    import riscv_pkg::*;

    localparam int LAT = 2;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic [2:0]    Funct3 = 3'b000;
    logic [31:0]   Addr = 32'h0;
    logic [31:0]   WrData = 32'h0;
    logic [31:0]   RdData;
    logic          Stall;
    logic          Done;
    logic          MisalignErr;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int en_cnt  = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] pipe [0:LAT-1];

    always #5 clk = ~clk;

    dmem_responder #(.MEM_LAT(LAT), .WORD_AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .Addr        (Addr),
        .WrData      (WrData),
        .RdData      (RdData),
        .Stall       (Stall),
        .Done        (Done),
        .MisalignErr (MisalignErr),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // SRAM model: byte-enabled write, read data valid LAT cycles after mem_en.
    always @(posedge clk) begin
        if (mem_en) en_cnt <= en_cnt + 1;
        if (mem_en && mem_we) begin
            wr_cnt <= wr_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        pipe[0] <= mem_en ? mem[mem_addr] : 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after Done.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic c1_en, output logic c1_we, output logic [3:0] c1_be,
                          output logic [AW-1:0] c1_addr, output logic [31:0] c1_wd);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
        lat = 0; rdata = 'x; err = 'x;
        c1_en = 'x; c1_we = 'x; c1_be = 'x; c1_addr = 'x; c1_wd = 'x;
        #1;
        chk("stall_on_request", Stall, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'hFFFF_FFFF; WrData = 32'h5555_5555;
            lat++;
            if (lat == 1) begin
                c1_en = mem_en; c1_we = mem_we; c1_be = mem_be; c1_addr = mem_addr; c1_wd = mem_wdata;
            end
            if (Done) begin
                rdata = RdData; err = MisalignErr;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int            lat;
    logic [31:0]   rd;
    logic          er, en1, we1;
    logic [3:0]    be1;
    logic [AW-1:0] ad1;
    logic [31:0]   wd1;
    logic [31:0]   prev;
    int            cnt_before;

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
        mem[1] = 32'h1122_3344;
        mem[3] = 32'h80FF_7F01;
        mem[4] = 32'hCAFE_F00D;

        // Reset with a request pending: everything must stay low.
        MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'hFFFF_FFFF; WrData = 32'hFFFF_FFFF;
        #12;
        chk("rst_stall", Stall, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", MisalignErr, 1'b0);
        chk("rst_en_we", {mem_en, mem_we}, 2'b00);
        chk("rst_be", mem_be, 4'b0000);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rddata", RdData, 32'h0);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;

        // SW word 2
        access(1'b0, 1'b1, F3_W, 32'h0000_0008, 32'hDEAD_BEEF, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("sw_en_we", {en1, we1}, 2'b11);
        chk("sw_addr", ad1, 2);
        chk("sw_be", be1, 4'b1111);
        chk("sw_wdata", wd1, 32'hDEAD_BEEF);
        chk("sw_lat", lat, 2);
        chk("sw_rd_hold", rd, 32'h0);
        chk("sw_mem", mem[2], 32'hDEAD_BEEF);

        // Loads from word 3 = 0x80FF7F01
        access(1'b1, 1'b0, F3_B, 32'h0000_000D, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lb1_en_we", {en1, we1}, 2'b10);
        chk("lb1_addr", ad1, 3);
        chk("lb1_lat", lat, 3);
        chk("lb1_data", rd, 32'h0000_007F);
        access(1'b1, 1'b0, F3_B, 32'h0000_000E, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lb2_data", rd, 32'hFFFF_FFFF);
        access(1'b1, 1'b0, F3_BU, 32'h0000_000F, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lbu3_data", rd, 32'h0000_0080);
        chk("lbu3_lat", lat, 3);
        access(1'b1, 1'b0, F3_H, 32'h0000_000C, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lh0_data", rd, 32'h0000_7F01);
        access(1'b1, 1'b0, F3_H, 32'h0000_000E, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lh2_data", rd, 32'hFFFF_80FF);
        access(1'b1, 1'b0, F3_HU, 32'h0000_000E, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("lhu2_data", rd, 32'h0000_80FF);
        chk("lhu2_err", er, 1'b0);

        // Misaligned LW at 0x05
        cnt_before = en_cnt;
        access(1'b1, 1'b0, F3_W, 32'h0000_0005, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_en", en1, 1'b0);
        chk("mis_lat", lat, 1);
        chk("mis_err", er, 1'b1);
        chk("mis_rd", rd, 32'h0);
        chk("mis_no_access", en_cnt, cnt_before);
        prev = 32'h0;
`else
        chk("mis_en", en1, 1'b1);
        chk("mis_addr", ad1, 1);
        chk("mis_lat", lat, 3);
        chk("mis_err", er, 1'b0);
        chk("mis_rd", rd, 32'h1122_3344);
        prev = 32'h1122_3344;
`endif

        // SH at 0x06 into word 1
        access(1'b0, 1'b1, F3_H, 32'h0000_0006, 32'h1234_ABCD, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("sh_be", be1, 4'b1100);
        chk("sh_wdata", wd1, 32'hABCD_ABCD);
        chk("sh_addr", ad1, 1);
        chk("sh_lat", lat, 2);
        chk("sh_rd_hold", rd, prev);
        chk("sh_mem", mem[1], 32'hABCD_3344);

        // Read and write together: store wins
        cnt_before = wr_cnt;
        access(1'b1, 1'b1, F3_W, 32'h0000_0000, 32'h5A5A_1234, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("rw_we", we1, 1'b1);
        chk("rw_lat", lat, 2);
        chk("rw_rd_hold", rd, prev);
        chk("rw_mem", mem[0], 32'h5A5A_1234);
        chk("rw_wr_cnt", wr_cnt, cnt_before + 1);

        // Undefined Funct3 behaves as LW
        access(1'b1, 1'b0, 3'b111, 32'h0000_000C, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("f3x_data", rd, 32'h80FF_7F01);

        // Reset during WAIT of a load
        MemRead = 1'b1; Funct3 = F3_W; Addr = 32'h0000_0010;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        chk("wait_stall", Stall, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_stall", Stall, 1'b0);
        chk("arst_en_we", {mem_en, mem_we}, 2'b00);
        chk("arst_done_err", {Done, MisalignErr}, 2'b00);
        chk("arst_be", mem_be, 4'b0000);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_rd", RdData, 32'h0);
        chk("arst_state", dut.state_q, IDLE);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset during ISSUE of a store: the write must be dropped
        cnt_before = wr_cnt;
        MemWrite = 1'b1; Funct3 = F3_W; Addr = 32'h0000_0014; WrData = 32'h7777_7777;
        @(posedge clk); #1;
        MemWrite = 1'b0;
        chk("sissue_we", mem_we, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("sarst_we", mem_we, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("sarst_no_write", wr_cnt, cnt_before);
        chk("sarst_mem", mem[5], 32'h0);

        // Normal LW after reset
        access(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, lat, rd, er, en1, we1, be1, ad1, wd1);
        chk("post_lw_data", rd, 32'hCAFE_F00D);
        chk("post_lw_lat", lat, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
